seq_alu_accumulator: RTL
========================

Name: seq_alu_accumulator

Overview:
Parametrised successor to the 4-bit lab ALU/register pair. It is an N-bit operand ALU with an internal 2N-bit accumulator, eight ops, and a valid/ready input handshake. Multiply is iterative (shift-add, WIDTH cycles) rather than a combinational array, so the block scales with WIDTH. It sits between the switch/key input logic and the LED/HEX display drivers, which show acc.

Parameters:
WIDTH, 4, operand width N; acc width is 2*WIDTH (derived, not overridable); legal WIDTH >= 2

Ports:
clk  input  1  system clock, all state on rising edge
reset  input  1  synchronous, active-high; clears all state
in_valid  input  1  op/operand presented this cycle
in_ready  output  1  high only in IDLE; transfer occurs when in_valid & in_ready at a rising edge
op  input  3  operation select, sampled on transfer
operand  input  WIDTH  operand B, sampled on transfer
acc  output  2*WIDTH  accumulator register; acc_lo = acc[WIDTH-1:0]
carry  output  1  registered carry flag
zero  output  1  combinational, (acc == 0)
busy  output  1  high while in MUL state
done  output  1  one-cycle pulse in the cycle after acc is written by any op

Behaviour:
- Reset (synchronous, active-high): acc=0, carry=0, done=0, state=IDLE, in_ready=1, busy=0, zero=1. Reset wins over a simultaneous transfer.
- States: IDLE, MUL. IDLE->MUL on transfer with op=111. MUL->IDLE after the WIDTH-th iteration. All other ops stay in IDLE.
- Ops (results zero-extended to 2*WIDTH unless stated):
  - 000: operand+1 as a (WIDTH+1)-bit result; carry = bit WIDTH.
  - 001: acc_lo+operand as a (WIDTH+1)-bit result; carry = bit WIDTH.
  - 010: acc+operand (zero-extended) mod 2^(2W); carry = carry-out of bit 2W-1.
  - 011: acc = {operand|acc_lo, operand^acc_lo}; carry=0.
  - 100: acc = reduction-OR over {acc_lo, operand} (1 bit); carry=0.
  - 101: (acc_lo << operand) truncated to WIDTH bits; a shift amount >= WIDTH gives 0; carry=0.
  - 110: acc_lo >> operand, logical; a shift amount >= WIDTH gives 0; carry=0.
  - 111: acc = acc_lo*operand, unsigned, full 2W bits; carry=0.
- Single-cycle ops (000-110): acc and carry update at the transfer edge; done=1 for the following cycle; in_ready stays high, so back-to-back transfers every cycle are legal.
- Multiply:
  - The transfer edge captures multiplicand=acc_lo, multiplier=operand, partial product=0; in_ready=0; busy=1.
  - One shift-add iteration per cycle for WIDTH cycles. acc holds its old value until the final iteration edge, where it is written with the product.
  - in_ready returns high and done pulses in the cycle after that edge. in_ready is low for exactly WIDTH cycles.
  - in_valid, op and operand are ignored while busy. Input changes mid-multiply must not affect the result.
- Reset mid-multiply: return to IDLE, acc=0, no done pulse, partial product discarded.
- done is never high for two consecutive cycles for one op. It is high on consecutive cycles only for back-to-back single-cycle ops.
- Undefined op values do not exist, since all 8 codes are used. An X on op during a transfer is a bench error.

Test Plan:
- WIDTH=4, assert reset 2 cycles -> acc=0x00, carry=0, zero=1, in_ready=1, done=0.
- op=000 operand=0xF -> next cycle acc=0x10, carry=1, done=1 for one cycle. Then op=110 operand=4 -> acc=0x00 (acc_lo was 0), zero=1, carry=0.
- Set acc_lo=0xD via op=001 (from acc 0) -> acc=0x0D. Then op=111 operand=0xB -> in_ready low exactly 4 cycles, operand toggled during busy has no effect, acc=0x8F, done pulses once.
- From acc=0x0D: op=101 operand=2 -> acc=0x04. op=101 operand=5 -> acc=0x00, zero=1.
- From acc=0x00: op=011 operand=0xF -> acc=0xFF. Then op=010 operand=0x1 -> acc=0x00, carry=1, zero=1.
- Start op=111, assert reset on cycle 2 of MUL -> acc=0, in_ready=1 next cycle, no done pulse. Repeat with WIDTH=8: 0xFF*0xFF -> acc=0xFE01 after 8 busy cycles.

Source files
------------

// File: rtl/seq_alu_accumulator.sv
`default_nettype none
// ============================================================================
// Module      : seq_alu_accumulator
// Description : N-bit operand ALU with a 2N-bit accumulator, eight ops,
//               valid/ready input and an iterative shift-add multiplier.
// Revision    : 1.0 - initial release
// ============================================================================
module seq_alu_accumulator #(
    parameter int WIDTH = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [2:0]           op,
    input  logic [WIDTH-1:0]     operand,
    output logic [2*WIDTH-1:0]   acc,
    output logic                 carry,
    output logic                 zero,
    output logic                 busy,
    output logic                 done
);

    localparam int c_AW = 2 * WIDTH;
    localparam int c_CW = $clog2(WIDTH);
    localparam logic [c_CW-1:0] c_LAST = c_CW'(WIDTH - 1);

    localparam logic [0:0] c_IDLE = 1'b0;
    localparam logic [0:0] c_MUL  = 1'b1;

    localparam logic [2:0] c_OP_INC  = 3'b000;
    localparam logic [2:0] c_OP_ADDL = 3'b001;
    localparam logic [2:0] c_OP_ADDW = 3'b010;
    localparam logic [2:0] c_OP_LOGI = 3'b011;
    localparam logic [2:0] c_OP_ROR  = 3'b100;
    localparam logic [2:0] c_OP_SHL  = 3'b101;
    localparam logic [2:0] c_OP_SHR  = 3'b110;
    localparam logic [2:0] c_OP_MUL  = 3'b111;

    logic [0:0]       r_state_q,  w_state_d;
    logic [c_AW-1:0]  r_acc_q,    w_acc_d;
    logic             r_carry_q,  w_carry_d;
    logic             r_done_q,   w_done_d;
    logic [c_AW-1:0]  r_mcand_q,  w_mcand_d;
    logic [WIDTH-1:0] r_mplier_q, w_mplier_d;
    logic [c_AW-1:0]  r_prod_q,   w_prod_d;
    logic [c_CW-1:0]  r_cnt_q,    w_cnt_d;

    logic             w_in_ready;
    logic             w_busy;
    logic             w_xfer;
    logic             w_last;
    logic [WIDTH-1:0] w_acc_lo;
    logic [WIDTH:0]   w_sum_inc;
    logic [WIDTH:0]   w_sum_lo;
    logic [c_AW:0]    w_sum_acc;
    logic [WIDTH-1:0] w_shl;
    logic [WIDTH-1:0] w_shr;
    logic [c_AW-1:0]  w_prod_next;

    assign w_acc_lo    = r_acc_q[WIDTH-1:0];
    assign w_xfer      = in_valid & w_in_ready;
    assign w_last      = (r_state_q == c_MUL) && (r_cnt_q == c_LAST);
    assign w_sum_inc   = {1'b0, operand} + {{WIDTH{1'b0}}, 1'b1};
    assign w_sum_lo    = {1'b0, w_acc_lo} + {1'b0, operand};
    assign w_sum_acc   = {1'b0, r_acc_q} + {{(c_AW + 1 - WIDTH){1'b0}}, operand};
    // Shifting a WIDTH-bit value by WIDTH or more moves every bit out, giving 0.
    assign w_shl       = w_acc_lo << operand;
    assign w_shr       = w_acc_lo >> operand;
    assign w_prod_next = r_prod_q + (r_mplier_q[0] ? r_mcand_q : {c_AW{1'b0}});

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state_q  <= c_IDLE;
            r_acc_q    <= '0;
            r_carry_q  <= 1'b0;
            r_done_q   <= 1'b0;
            r_mcand_q  <= '0;
            r_mplier_q <= '0;
            r_prod_q   <= '0;
            r_cnt_q    <= '0;
        end else begin
            r_state_q  <= w_state_d;
            r_acc_q    <= w_acc_d;
            r_carry_q  <= w_carry_d;
            r_done_q   <= w_done_d;
            r_mcand_q  <= w_mcand_d;
            r_mplier_q <= w_mplier_d;
            r_prod_q   <= w_prod_d;
            r_cnt_q    <= w_cnt_d;
        end
    end

    always_comb begin
        w_state_d = r_state_q;
        case (r_state_q)
            c_IDLE:  if (w_xfer && (op == c_OP_MUL)) w_state_d = c_MUL;
            c_MUL:   if (w_last) w_state_d = c_IDLE;
            default: w_state_d = c_IDLE;
        endcase
    end

    always_comb begin
        w_in_ready = (r_state_q == c_IDLE);
        w_busy     = (r_state_q == c_MUL);
    end

    always_comb begin
        w_acc_d    = r_acc_q;
        w_carry_d  = r_carry_q;
        w_done_d   = 1'b0;
        w_mcand_d  = r_mcand_q;
        w_mplier_d = r_mplier_q;
        w_prod_d   = r_prod_q;
        w_cnt_d    = r_cnt_q;
        if (r_state_q == c_IDLE) begin
            if (w_xfer) begin
                w_carry_d = 1'b0;
                w_done_d  = (op != c_OP_MUL);
                case (op)
                    c_OP_INC: begin
                        w_acc_d   = {{(c_AW - WIDTH - 1){1'b0}}, w_sum_inc};
                        w_carry_d = w_sum_inc[WIDTH];
                    end
                    c_OP_ADDL: begin
                        w_acc_d   = {{(c_AW - WIDTH - 1){1'b0}}, w_sum_lo};
                        w_carry_d = w_sum_lo[WIDTH];
                    end
                    c_OP_ADDW: begin
                        w_acc_d   = w_sum_acc[c_AW-1:0];
                        w_carry_d = w_sum_acc[c_AW];
                    end
                    c_OP_LOGI: w_acc_d = {operand | w_acc_lo, operand ^ w_acc_lo};
                    c_OP_ROR:  w_acc_d = {{(c_AW - 1){1'b0}}, |{w_acc_lo, operand}};
                    c_OP_SHL:  w_acc_d = {{WIDTH{1'b0}}, w_shl};
                    c_OP_SHR:  w_acc_d = {{WIDTH{1'b0}}, w_shr};
                    default: begin
                        // Multiply: acc keeps its old value until the last iteration.
                        w_carry_d  = r_carry_q;
                        w_mcand_d  = {{WIDTH{1'b0}}, w_acc_lo};
                        w_mplier_d = operand;
                        w_prod_d   = '0;
                        w_cnt_d    = '0;
                    end
                endcase
            end
        end else begin
            w_prod_d   = w_prod_next;
            w_mcand_d  = r_mcand_q << 1;
            w_mplier_d = r_mplier_q >> 1;
            w_cnt_d    = r_cnt_q + c_CW'(1);
            if (w_last) begin
                w_acc_d   = w_prod_next;
                w_carry_d = 1'b0;
                w_done_d  = 1'b1;
            end
        end
    end

    assign in_ready = w_in_ready;
    assign busy     = w_busy;
    assign acc      = r_acc_q;
    assign carry    = r_carry_q;
    assign done     = r_done_q;
    assign zero     = (r_acc_q == {c_AW{1'b0}});

endmodule
`default_nettype wire
